mem_arbiter: RTL

Two-master arbiter that shares the single-port data RAM (combinational read, write on rising clock edge) between two requesters, for example the CPU data port (master 0) and a loader/debug port (master 1). It sits directly in front of the RAM and drives its address, write data and write enable. It uses a round-robin policy with a bounded hold count under contention. It returns read data to the winning master on a registered response one cycle later.

---
 rtl/mem_arbiter.sv | 72 +++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin two-master arbiter with bounded hold in front of a single-port RAM
// Ports: clk/rst (async active-high); mX_req/we/addr/wdata in, mX_gnt (combinational),
// mX_rvalid/mX_rdata (registered read response) out; ram_addr/wdata/we out, ram_rdata in.
module mem_arbiter #(
  parameter int MAX_HOLD = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m0_gnt,
  output logic        m1_gnt,
  output logic        m0_rvalid,
  output logic        m1_rvalid,
  output logic [31:0] m0_rdata,
  output logic [31:0] m1_rdata,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  output logic        ram_we,
  input  logic [31:0] ram_rdata
);
  localparam int RW = $clog2(MAX_HOLD + 1);
  logic          last_q, last_d;
  logic [RW-1:0] run_q, run_d;
  logic          m0_rvalid_q, m0_rvalid_d, m1_rvalid_q, m1_rvalid_d;
  logic [31:0]   m0_rdata_q, m0_rdata_d, m1_rdata_q, m1_rdata_d;
  logic          sat, pick1, any;
  always_comb begin
    sat = run_q == RW'(MAX_HOLD);
    // under contention m1 wins when it is last and not saturated, or m0 is last and saturated
    pick1 = m1_req & (~m0_req | (last_q ^ sat));
    m1_gnt = ~rst & pick1;
    m0_gnt = ~rst & m0_req & ~pick1;
    any = m0_gnt | m1_gnt;
    ram_addr = m1_gnt ? m1_addr : m0_gnt ? m0_addr : '0;
    ram_wdata = m1_gnt ? m1_wdata : m0_gnt ? m0_wdata : '0;
    ram_we = m1_gnt ? m1_we : m0_gnt & m0_we;
    last_d = any ? m1_gnt : last_q;
    run_d = ~any ? '0 : (m1_gnt != last_q) ? RW'(1) : sat ? run_q : run_q + 1'b1;
    m0_rvalid_d = m0_gnt & ~m0_we;
    m1_rvalid_d = m1_gnt & ~m1_we;
    m0_rdata_d = m0_rvalid_d ? ram_rdata : m0_rdata_q;
    m1_rdata_d = m1_rvalid_d ? ram_rdata : m1_rdata_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= 1'b0;
      run_q <= '0;
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
    end else begin
      last_q <= last_d;
      run_q <= run_d;
      m0_rvalid_q <= m0_rvalid_d;
      m1_rvalid_q <= m1_rvalid_d;
      m0_rdata_q <= m0_rdata_d;
      m1_rdata_q <= m1_rdata_d;
    end
  end
  assign m0_rvalid = m0_rvalid_q;
  assign m1_rvalid = m1_rvalid_q;
  assign m0_rdata = m0_rdata_q;
  assign m1_rdata = m1_rdata_q;
endmodule
